// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the memory-stage controller (master) and the
// data memory (slave).
//
// Handshake: the master raises dmem_req_o with dmem_we_o/dmem_addr_o/
// dmem_wdata_o stable and holds them until a cycle in which
// dmem_req_o && dmem_ready_i; that cycle completes the transfer, and
// dmem_rdata_i / dmem_err_i are meaningful only in that cycle. The master
// withdraws dmem_req_o without a transfer only on timeout or reset, so the
// slave must tolerate an abandoned request. dmem_ready_i while dmem_req_o is
// low has no effect.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 64
) ();
   logic              dmem_req_o;
   logic              dmem_we_o;
   logic [ADDR_W-1:0] dmem_addr_o;
   logic [63:0]       dmem_wdata_o;
   logic              dmem_ready_i;
   logic [63:0]       dmem_rdata_i;
   logic              dmem_err_i;

   modport master (
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
      input  dmem_ready_i, dmem_rdata_i, dmem_err_i
   );

   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
      output dmem_ready_i, dmem_rdata_i, dmem_err_i
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Y86-64 memory-stage controller. Decodes the instruction held in M, issues
// one bounded, time-limited data-memory access per memory instruction and
// stalls the pipeline until the result (valM, status) is ready for writeback.
module mem_access_ctrl #(
   parameter int ADDR_W         = 64,
   parameter int MEM_BYTES      = 1024,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [3:0]        M_icode_i,
   input  logic [2:0]        M_stat_i,
   input  logic [63:0]       M_valE_i,
   input  logic [63:0]       M_valA_i,
   input  logic [2:0]        W_stat_i,
   mem_access_ctrl_if.master dmem,
   output logic              m_busy_o,
   output logic [63:0]       m_valM_o,
   output logic [2:0]        m_stat_o,
   output logic [1:0]        dbg_state_o
);

   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_ADR = 3'd3;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [63:0]     ADDR_MAX = 64'(MEM_BYTES - 8);

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_err;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [63:0]       r_wdata;
   logic [63:0]       r_valM;

   logic              w_is_read;
   logic              w_is_write;
   logic              w_addr_from_a;
   logic [63:0]       w_addr;
   logic              w_pending;
   logic              w_in_range;
   logic              w_start;
   logic              w_oob;
   logic              w_xfer;
   logic              w_timeout;

   // Decode the instruction in M into access class, address and eligibility.
   assign w_is_read     = (M_icode_i == I_MRMOVQ) || (M_icode_i == I_POPQ) || (M_icode_i == I_RET);
   assign w_is_write    = (M_icode_i == I_RMMOVQ) || (M_icode_i == I_PUSHQ) || (M_icode_i == I_CALL);
   assign w_addr_from_a = (M_icode_i == I_POPQ) || (M_icode_i == I_RET);
   assign w_addr        = w_addr_from_a ? M_valA_i : M_valE_i;
   // A write is suppressed when writeback already holds an exception.
   assign w_pending     = (w_is_read || w_is_write) && (M_stat_i == STAT_AOK) &&
                          !(w_is_write && (W_stat_i != STAT_AOK));
   // Range check on the full 64-bit address so truncation never hides a fault.
   assign w_in_range    = (w_addr <= ADDR_MAX);
   assign w_start       = (r_state == S_IDLE) && w_pending && w_in_range;
   assign w_oob         = (r_state == S_IDLE) && w_pending && !w_in_range;
   assign w_xfer        = (r_state == S_REQ) && dmem.dmem_ready_i;
   // Ready in the last allowed cycle takes priority over the timeout.
   assign w_timeout     = (r_state == S_REQ) && !dmem.dmem_ready_i && (r_cnt == CNT_LAST);

   // Bus outputs come straight from registers so they stay stable while waiting.
   assign dmem.dmem_req_o   = (r_state == S_REQ);
   assign dmem.dmem_we_o    = r_we;
   assign dmem.dmem_addr_o  = r_addr;
   assign dmem.dmem_wdata_o = r_wdata;

   // Stall M while an access is being detected or is in flight.
   assign m_busy_o    = !rst_i && ((r_state == S_REQ) || w_start);
   assign m_valM_o    = r_valM;
   assign dbg_state_o = r_state;

   // Status to writeback: bus fault in DONE, bounds fault while detecting.
   always_comb begin
      m_stat_o = M_stat_i;
      if (!rst_i) begin
         if (r_state == S_DONE) begin
            if (r_err) m_stat_o = STAT_ADR;
         end else if (w_oob) begin
            m_stat_o = STAT_ADR;
         end
      end
   end

   // Access FSM: latch the request at REQ entry, wait for ready or timeout.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_valM  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state <= S_REQ;
                  r_cnt   <= '0;
                  r_addr  <= ADDR_W'(w_addr);
                  r_we    <= w_is_write;
                  r_wdata <= M_valA_i;
               end
            end
            S_REQ: begin
               if (w_xfer) begin
                  r_state <= S_DONE;
                  r_err   <= dmem.dmem_err_i;
                  if (!r_we) r_valM <= dmem.dmem_rdata_i;
               end else if (w_timeout) begin
                  r_state <= S_DONE;
                  r_err   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
